// File: rtl/phase_diff_meter.sv
// phase_diff_meter: measures the clk_fx period and the lag of clk_fx2 behind clk_fx,
// both counted in sys_clk cycles, with a one-cycle valid strobe per clk_fx period.
// Ports: sys_clk, rst_n (async, active low); clk_fx, clk_fx2 asynchronous test inputs;
//        period_cnt, lag_cnt results; meas_valid, no_ref_err, timeout one-cycle pulses.
module phase_diff_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clk_fx,
    input  logic             clk_fx2,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] lag_cnt,
    output logic             meas_valid,
    output logic             no_ref_err,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LAG  = 2'd1;
    localparam logic [1:0] S_PER  = 2'd2;

    // Counter value in the cycle that is TIMEOUT_CYC cycles after the opening edge.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic                   r_dly_a;
    logic                   r_dly_b;
    logic                   w_rise_a;
    logic                   w_rise_b;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lag;
    logic [CNT_W-1:0] r_period_out;
    logic [CNT_W-1:0] r_lag_out;
    logic             r_valid;
    logic             r_noref;
    logic             r_tmo;

    logic [1:0]       w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_p1;
    logic [CNT_W-1:0] w_lag;
    logic [CNT_W-1:0] w_period_out;
    logic [CNT_W-1:0] w_lag_out;
    logic             w_valid;
    logic             w_noref;
    logic             w_tmo;
    logic             w_tmo_hit;

    // Same depth on both channels, so the detection latency cancels in the results.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_dly_a  <= 1'b0;
            r_dly_b  <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], clk_fx};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], clk_fx2};
            r_dly_a  <= r_sync_a[SYNC_STAGES-1];
            r_dly_b  <= r_sync_b[SYNC_STAGES-1];
        end
    end

    assign w_rise_a  = r_sync_a[SYNC_STAGES-1] & ~r_dly_a;
    assign w_rise_b  = r_sync_b[SYNC_STAGES-1] & ~r_dly_b;
    assign w_cnt_p1  = r_cnt + CNT_W'(1);
    assign w_tmo_hit = (r_cnt == TMO_LAST);

    always_comb begin
        w_state      = r_state;
        w_cnt        = w_cnt_p1;
        w_lag        = r_lag;
        w_period_out = r_period_out;
        w_lag_out    = r_lag_out;
        w_valid      = 1'b0;
        w_noref      = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (w_rise_a) begin
                    w_lag   = '0;
                    w_state = w_rise_b ? S_PER : S_LAG;
                end
            end
            S_LAG: begin
                if (w_rise_a) begin
                    // A closed a period before any B edge arrived.
                    w_noref = 1'b1;
                    w_cnt   = '0;
                    if (w_rise_b) begin
                        w_lag   = '0;
                        w_state = S_PER;
                    end
                end else if (w_rise_b) begin
                    w_lag   = w_cnt_p1;
                    w_state = S_PER;
                end else if (w_tmo_hit) begin
                    w_tmo   = 1'b1;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end
            end
            S_PER: begin
                if (w_rise_a) begin
                    // Closing edge of this period also opens the next one.
                    w_valid      = 1'b1;
                    w_period_out = w_cnt_p1;
                    w_lag_out    = r_lag;
                    w_cnt        = '0;
                    if (w_rise_b) begin
                        w_lag   = '0;
                        w_state = S_PER;
                    end else begin
                        w_state = S_LAG;
                    end
                end else if (w_tmo_hit) begin
                    w_tmo   = 1'b1;
                    w_cnt   = '0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_cnt   = '0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_lag        <= '0;
            r_period_out <= '0;
            r_lag_out    <= '0;
            r_valid      <= 1'b0;
            r_noref      <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_lag        <= w_lag;
            r_period_out <= w_period_out;
            r_lag_out    <= w_lag_out;
            r_valid      <= w_valid;
            r_noref      <= w_noref;
            r_tmo        <= w_tmo;
        end
    end

    assign period_cnt = r_period_out;
    assign lag_cnt    = r_lag_out;
    assign meas_valid = r_valid;
    assign no_ref_err = r_noref;
    assign timeout    = r_tmo;

endmodule

// File: tb/tb_phase_diff_meter.sv
// tb_phase_diff_meter: table vectors, hand sequences and random edge streams
// checked against an edge-list reference model of phase_diff_meter.
module tb_phase_diff_meter;

    localparam int CNT_W = 32;
    localparam int TMO   = 2000;
    localparam int NMAX  = 16000;

    logic             sys_clk = 1'b0;
    logic             rst_n   = 1'b0;
    logic             clk_fx  = 1'b0;
    logic             clk_fx2 = 1'b0;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] lag_cnt;
    logic             meas_valid;
    logic             no_ref_err;
    logic             timeout;

    always #5 sys_clk = ~sys_clk;

    phase_diff_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .clk_fx    (clk_fx),
        .clk_fx2   (clk_fx2),
        .period_cnt(period_cnt),
        .lag_cnt   (lag_cnt),
        .meas_valid(meas_valid),
        .no_ref_err(no_ref_err),
        .timeout   (timeout)
    );

    typedef struct {
        int p;
        int l;
        bit g;
        int ep;
        int el;
    } vec_t;

    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    bit mon_en = 1'b0;
    bit clr = 1'b0;
    int q_per[$];
    int q_lag[$];
    int q_cyc[$];
    int nref_n = 0;
    int tout_n = 0;
    int tout_cyc = 0;

    bit a_lv[NMAX];
    bit b_lv[NMAX];

    always @(negedge sys_clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            q_per.delete();
            q_lag.delete();
            q_cyc.delete();
            nref_n <= 0;
            tout_n <= 0;
        end else if (mon_en) begin
            if (meas_valid) begin
                q_per.push_back(int'(period_cnt));
                q_lag.push_back(int'(lag_cnt));
                q_cyc.push_back(cyc);
            end
            if (no_ref_err) nref_n <= nref_n + 1;
            if (timeout) begin
                tout_n   <= tout_n + 1;
                tout_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n   = 1'b0;
        clk_fx  = 1'b0;
        clk_fx2 = 1'b0;
        mon_en  = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_period", period_cnt, 0);
        chk("rst_lag", lag_cnt, 0);
        chk("rst_pulses", {meas_valid, no_ref_err, timeout}, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        clr   = 1'b1;
        @(negedge sys_clk);
        #1;
        clr    = 1'b0;
        mon_en = 1'b1;
    endtask

    // A rises every p cycles (high p/2); B rises l cycles after each A rise.
    task automatic run_periodic(input int p, input int l, input bit g,
                                input int ncyc, input int rst_at);
        int o;
        int wb;
        bit b;
        wb = p / 2;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge sys_clk);
            clk_fx = ((c % p) < wb);
            o = c - l;
            b = 1'b0;
            if (o >= 0) begin
                o = o % p;
                b = (o < wb) || (g && (o == wb + 1 || o == wb + 3));
            end
            clk_fx2 = b;
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_period", period_cnt, 0);
                chk("midrst_lag", lag_cnt, 0);
                chk("midrst_valid", meas_valid, 0);
            end
            if (c == rst_at + 3) rst_n = 1'b1;
        end
        @(negedge sys_clk);
        clk_fx  = 1'b0;
        clk_fx2 = 1'b0;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic run_random(input int nwin);
        int len, p, h, l, w, gi, fb, nref_e, n;
        int ar[$];
        int br[$];
        int e_per[$];
        int e_lag[$];
        int e_pin[$];
        bit pa, pb;
        for (int i = 0; i < NMAX; i++) begin
            a_lv[i] = 1'b0;
            b_lv[i] = 1'b0;
        end
        len = 0;
        for (int k = 0; k < nwin; k++) begin
            p = int'($urandom_range(300, 2));
            h = int'($urandom_range(p - 1, 1));
            for (int i = 0; i < h; i++) a_lv[len + i] = 1'b1;
            if ($urandom_range(5, 0) != 0) begin
                l = int'($urandom_range(p - 1, 0));
                w = int'($urandom_range(p, 1));
                for (int i = 0; i < w; i++)
                    if (len + l + i < NMAX) b_lv[len + l + i] = 1'b1;
            end
            if ($urandom_range(3, 0) == 0) begin
                gi = int'($urandom_range(p - 1, 0));
                b_lv[len + gi] = 1'b1;
            end
            len += p;
        end

        do_reset();
        for (int i = 0; i < len; i++) begin
            @(negedge sys_clk);
            clk_fx  = a_lv[i];
            clk_fx2 = b_lv[i];
        end
        @(negedge sys_clk);
        clk_fx  = 1'b0;
        clk_fx2 = 1'b0;
        repeat (20) @(negedge sys_clk);

        pa = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (a_lv[i] && !pa) ar.push_back(i);
            if (b_lv[i] && !pb) br.push_back(i);
            pa = a_lv[i];
            pb = b_lv[i];
        end
        nref_e = 0;
        for (int i = 0; i + 1 < ar.size(); i++) begin
            fb = -1;
            foreach (br[j])
                if (fb < 0 && br[j] >= ar[i] && br[j] < ar[i + 1]) fb = br[j];
            if (fb < 0) begin
                nref_e++;
            end else begin
                e_per.push_back(ar[i + 1] - ar[i]);
                e_lag.push_back(fb - ar[i]);
                e_pin.push_back(ar[i + 1]);
            end
        end

        chk("rnd_nvalid", q_per.size(), e_per.size());
        chk("rnd_noref", nref_n, nref_e);
        chk("rnd_timeout", tout_n, 0);
        n = (q_per.size() < e_per.size()) ? q_per.size() : e_per.size();
        for (int j = 0; j < n; j++) begin
            chk($sformatf("rnd_period[%0d]", j), q_per[j], e_per[j]);
            chk($sformatf("rnd_lag[%0d]", j), q_lag[j], e_lag[j]);
            if (j > 0)
                chk($sformatf("rnd_strobe_time[%0d]", j),
                    q_cyc[j] - e_pin[j], q_cyc[0] - e_pin[0]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{200, 5, 1'b0, 200, 5};
        tbl[1] = '{200, 0, 1'b0, 200, 0};
        tbl[2] = '{100, 99, 1'b0, 100, 99};
        tbl[3] = '{200, 50, 1'b1, 200, 50};
        tbl[4] = '{2, 1, 1'b0, 2, 1};
        tbl[5] = '{37, 20, 1'b0, 37, 20};
        tbl[6] = '{300, 150, 1'b0, 300, 150};

        foreach (tbl[i]) begin
            do_reset();
            run_periodic(tbl[i].p, tbl[i].l, tbl[i].g, 4 * tbl[i].p, -1);
            chk($sformatf("vec%0d_nvalid", i), q_per.size(), 3);
            for (int j = 0; j < q_per.size() && j < 3; j++) begin
                chk($sformatf("vec%0d_period[%0d]", i, j), q_per[j], tbl[i].ep);
                chk($sformatf("vec%0d_lag[%0d]", i, j), q_lag[j], tbl[i].el);
            end
            chk($sformatf("vec%0d_noref", i), nref_n, 0);
            chk($sformatf("vec%0d_timeout", i), tout_n, 0);
        end

        // B held low: one no_ref_err per A period, no results.
        do_reset();
        run_periodic(150, 100000, 1'b0, 600, -1);
        chk("noB_noref", nref_n, 3);
        chk("noB_nvalid", q_per.size(), 0);
        chk("noB_period", period_cnt, 0);
        chk("noB_lag", lag_cnt, 0);

        // A stops after two valid periods: one timeout, results held.
        do_reset();
        run_periodic(200, 5, 1'b0, 401, -1);
        repeat (TMO + 50) @(negedge sys_clk);
        chk("tmo_nvalid", q_per.size(), 2);
        chk("tmo_count", tout_n, 1);
        if (q_cyc.size() == 2 && tout_n == 1)
            chk("tmo_delay", tout_cyc - q_cyc[1], TMO);
        chk("tmo_hold_period", period_cnt, 200);
        chk("tmo_hold_lag", lag_cnt, 5);

        // Reset pulse while in PER: two fresh A edges needed afterwards.
        do_reset();
        run_periodic(200, 5, 1'b0, 1000, 520);
        chk("midrst_nvalid", q_per.size(), 3);
        for (int j = 0; j < q_per.size() && j < 3; j++) begin
            chk($sformatf("midrst_per[%0d]", j), q_per[j], 200);
            chk($sformatf("midrst_lagv[%0d]", j), q_lag[j], 5);
        end
        if (q_cyc.size() == 3)
            chk("midrst_gap", q_cyc[2] - q_cyc[1], 400);

        run_random(40);
        run_random(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
